sha256_msg_padder: RTL
======================

Name: sha256_msg_padder

Overview:
- Upstream feeder for the simplified SHA-256 compression core.
- Fetches a fixed-length message of NUM_OF_WORDS 32-bit words from the shared single-port word memory, starting at message_addr.
- Appends SHA-256 padding: 0x80000000, then zero words, then the 64-bit bit-length.
- Streams the padded message as 16-word blocks over a valid/ready word interface; the core then only sees complete blocks.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words (1..1000).
- NUM_BLOCKS, (NUM_OF_WORDS+18)/16 (integer division), derived; number of 512-bit blocks emitted.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin a message; sampled in IDLE only
- message_addr  in  16  word address of message word 0; latched on accepted start
- mem_clk  out  1  memory clock, equal to clk
- mem_we  out  1  constant 0 (read-only client)
- mem_addr  out  16  registered read address
- mem_read_data  in  32  memory samples mem_addr on a rising edge; data is stable after that edge
- out_valid  out  1  out_word is valid
- out_ready  in  1  consumer accepts the word
- out_word  out  32  padded message word
- out_idx  out  4  word index within the current block (0..15)
- out_blk_last  out  1  out_idx==15
- out_msg_last  out  1  final word of the final block
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final word is transferred

Behaviour:
- Reset values (synchronous, all outputs): state IDLE, out_valid=0, out_word=0, out_idx=0, mem_addr=0, done=0, busy=0; internal word counter g=0.
- Global word index g runs 0..NUM_BLOCKS*16-1. out_idx=g[3:0].
- Word content by g:
  - g<NUM_OF_WORDS: mem[message_addr+g].
  - g==NUM_OF_WORDS: 0x80000000.
  - g==NUM_BLOCKS*16-1: NUM_OF_WORDS*32, 32-bit.
  - all other g (including the upper length word): 0.
- Transfer occurs on any rising edge with out_valid&&out_ready.
  - out_valid, once high, stays high and out_word stays stable until the transfer; never retracted.
- FSM states: IDLE, RD_WAIT, RD_CAP, OUT, DONE.
  - IDLE: on start, latch message_addr, set g=0, set mem_addr=message_addr, go to RD_WAIT.
  - RD_WAIT: go to RD_CAP. Memory samples the address on this edge.
  - RD_CAP: out_word<=mem_read_data, out_valid<=1, go to OUT. Latency from the start edge to out_valid high is 3 edges.
  - OUT, on transfer: g<=g+1.
    - If g was the last word: out_valid<=0, go to DONE.
    - Else if g+1<NUM_OF_WORDS: out_valid<=0, mem_addr<=message_addr+g+1, go to RD_WAIT.
    - Else: load the pad word for g+1 directly and stay in OUT. Padding streams at 1 word per cycle under continuous out_ready.
  - DONE: done=1 for exactly one cycle, go to IDLE.
- Address arithmetic is 16-bit and wraps modulo 2^16.
- start while busy is ignored. start held high across the DONE→IDLE boundary begins a new message on the first IDLE cycle.
- reset_n low in any state: all outputs return to reset values on that edge; an in-flight read result is discarded.
- out_ready high while out_valid is low has no effect.

Optional Feature:
- Macro PADDER_NONCE_EN.
- Defined:
  - Adds input nonce[31:0].
  - Word g==NUM_OF_WORDS-1 is taken from nonce, which is sampled when that word is loaded. No memory read is issued for it; the word is loaded directly into OUT like a pad word.
  - Intended for the bitcoin nonce sweep.
- Undefined: no nonce port; all message words come from memory.

Decomposition:
- Shared package sha256_pkg holds:
  - word_t (logic [31:0]);
  - PAD_WORD=32'h80000000;
  - padder_state_t enum;
  - function num_blocks(int words).
- One sub-module, sha256_pad_word_gen: combinational map from (g, NUM_OF_WORDS) to {pad_word, is_msg_word, is_last}. The FSM instantiates it once.

Test Plan:
- NUM_OF_WORDS=20, seed 0x01234567 with each next word = rotl1 of the previous, word 19=0, out_ready=1 -> 32 words. Words 0..19 match memory, g20=0x80000000 (out_idx=4), g21..30=0, g31=0x00000280 with out_blk_last=1 and out_msg_last=1, then done pulses once.
- NUM_OF_WORDS=13 -> single block. g13=0x80000000, g14=0, g15=0x000001A0, out_msg_last at out_idx=15.
- Random out_ready throttling with a 30% stall rate -> identical 32-word sequence. out_word never changes while out_valid=1 and out_ready=0.
- Pulse reset_n low at g=7 -> next cycle out_valid=0, busy=0, mem_addr=0. A fresh start then restarts from g=0 with correct data.
- Assert start at g=5 with message_addr=0x0200 -> ignored. Reads continue from the originally latched address; mem_we remains 0 throughout.
- With PADDER_NONCE_EN and nonce=0xDEADBEEF -> g19=0xDEADBEEF, no mem_addr=message_addr+19 read issued, rest identical to the first scenario.

Source files
------------

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared types and helpers for the SHA-256 front end.
//   word_t         : 32-bit message word
//   PAD_WORD       : first padding word (single 1 bit after the message)
//   G_W            : width of the global padded-word counter
//   padder_state_t : message padder FSM states
//   num_blocks()   : number of 512-bit blocks for a message of N words
//                    (message + 1 pad word + 2 length words, rounded up)
// ---------------------------------------------------------------------------
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PAD_WORD = 32'h8000_0000;
    localparam int    G_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_CAP,
        OUT,
        DONE
    } padder_state_t;

    function automatic int num_blocks(input int words);
        return (words + 18) / 16;
    endfunction

endpackage

// File: rtl/sha256_pad_word_gen.sv
// ---------------------------------------------------------------------------
// sha256_pad_word_gen
// Combinational classification of a global padded-word index.
// Ports:
//   i_g           in  G_W  global word index into the padded message
//   o_pad_word    out 32   padding content for i_g (0 for message words)
//   o_is_msg_word out 1    i_g addresses a message word held in memory
//   o_is_last     out 1    i_g is the final word of the final block
// ---------------------------------------------------------------------------
module sha256_pad_word_gen
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic [G_W-1:0] i_g,
    output word_t          o_pad_word,
    output logic           o_is_msg_word,
    output logic           o_is_last
);

    localparam int             TOTAL_WORDS = num_blocks(NUM_OF_WORDS) * 16;
    localparam logic [G_W-1:0] PAD_G       = G_W'(NUM_OF_WORDS);
    localparam logic [G_W-1:0] LAST_G      = G_W'(TOTAL_WORDS - 1);
    // Low half of the 64-bit bit length; the high half is always zero here.
    localparam word_t          LEN_WORD    = word_t'(NUM_OF_WORDS * 32);

    always_comb begin
        o_pad_word    = '0;
        o_is_msg_word = (i_g < PAD_G);
        o_is_last     = (i_g == LAST_G);
        if (i_g == PAD_G) begin
            o_pad_word = PAD_WORD;
        end else if (o_is_last) begin
            o_pad_word = LEN_WORD;
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder
// Reads a NUM_OF_WORDS-word message from the shared word memory, appends
// SHA-256 padding and streams whole 16-word blocks over valid/ready.
// Optional build macro: PADDER_NONCE_EN (adds input nonce, which replaces
// the last message word without a memory read).
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   nonce         in  32  (PADDER_NONCE_EN only) last message word
//   start         in  1   begin a message (honoured in IDLE only)
//   message_addr  in  16  word address of message word 0
//   mem_clk/mem_we/mem_addr/mem_read_data   read-only memory port
//   out_valid/out_ready/out_word            padded word stream
//   out_idx       out 4   word index within block
//   out_blk_last  out 1   last word of a block
//   out_msg_last  out 1   last word of the message
//   busy          out 1   not IDLE
//   done          out 1   one-cycle pulse after the final transfer
// ---------------------------------------------------------------------------
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef PADDER_NONCE_EN
    input  logic [31:0] nonce,
`endif
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_idx,
    output logic        out_blk_last,
    output logic        out_msg_last,
    output logic        busy,
    output logic        done
);

    padder_state_t  r_state, w_state_next;
    logic [G_W-1:0] r_g, w_g_next;
    logic [15:0]    r_base, w_base_next;
    logic [15:0]    r_mem_addr, w_mem_addr_next;
    word_t          r_out_word, w_out_word_next;
    logic           r_out_valid, w_out_valid_next;
    logic           r_msg_last, w_msg_last_next;

    logic [G_W-1:0] w_g_inc;
    word_t          w_pad_word;
    logic           w_is_msg;
    logic           w_is_last;
    logic           w_nonce_next;
    logic           w_need_read;
    word_t          w_direct_word;
    word_t          w_cap_word;
    logic           w_xfer;

    assign w_g_inc = r_g + 1'b1;
    assign w_xfer  = r_out_valid && out_ready;

    // Classification is always for the word that follows the current one.
    sha256_pad_word_gen #(
        .NUM_OF_WORDS (NUM_OF_WORDS)
    ) u_pad_gen (
        .i_g           (w_g_inc),
        .o_pad_word    (w_pad_word),
        .o_is_msg_word (w_is_msg),
        .o_is_last     (w_is_last)
    );

`ifdef PADDER_NONCE_EN
    // The nonce word is normally loaded straight into OUT; the capture-path
    // mux only matters for a one-word message, where word 0 is the nonce.
    assign w_nonce_next  = (w_g_inc == G_W'(NUM_OF_WORDS - 1));
    assign w_direct_word = w_nonce_next ? nonce : w_pad_word;
    assign w_cap_word    = (r_g == G_W'(NUM_OF_WORDS - 1)) ? nonce : mem_read_data;
`else
    assign w_nonce_next  = 1'b0;
    assign w_direct_word = w_pad_word;
    assign w_cap_word    = mem_read_data;
`endif

    assign w_need_read = w_is_msg && !w_nonce_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_g         <= '0;
            r_base      <= '0;
            r_mem_addr  <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_msg_last  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_g         <= w_g_next;
            r_base      <= w_base_next;
            r_mem_addr  <= w_mem_addr_next;
            r_out_word  <= w_out_word_next;
            r_out_valid <= w_out_valid_next;
            r_msg_last  <= w_msg_last_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_g_next         = r_g;
        w_base_next      = r_base;
        w_mem_addr_next  = r_mem_addr;
        w_out_word_next  = r_out_word;
        w_out_valid_next = r_out_valid;
        w_msg_last_next  = r_msg_last;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_base_next     = message_addr;
                    w_mem_addr_next = message_addr;
                    w_g_next        = '0;
                    w_state_next    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                w_state_next = RD_CAP;
            end
            RD_CAP: begin
                // Memory words can never be the final (length) word.
                w_out_word_next  = w_cap_word;
                w_out_valid_next = 1'b1;
                w_msg_last_next  = 1'b0;
                w_state_next     = OUT;
            end
            OUT: begin
                if (w_xfer) begin
                    w_g_next = w_g_inc;
                    if (r_msg_last) begin
                        w_out_valid_next = 1'b0;
                        w_msg_last_next  = 1'b0;
                        w_state_next     = DONE;
                    end else if (w_need_read) begin
                        w_out_valid_next = 1'b0;
                        w_mem_addr_next  = r_base + w_g_inc;
                        w_state_next     = RD_WAIT;
                    end else begin
                        w_out_word_next = w_direct_word;
                        w_msg_last_next = w_is_last;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign mem_clk      = clk;
    assign mem_we       = 1'b0;
    assign mem_addr     = r_mem_addr;
    assign out_valid    = r_out_valid;
    assign out_word     = r_out_word;
    assign out_idx      = r_g[3:0];
    assign out_blk_last = (r_g[3:0] == 4'hF);
    assign out_msg_last = r_msg_last;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);

endmodule
